// File: rtl/pkt_tx_arb.sv
// pkt_tx_arb: credit-gated round-robin packet arbiter.
// Grants one requester at a time, holds the grant for a whole packet and
// registers the accepted beat toward the packet bus. A credit counter
// mirrors the receiver buffer, so a beat is only accepted while credits remain.
module pkt_tx_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 64,
    parameter int CREDIT_MAX = 8,
    parameter int CNT_W      = $clog2(CREDIT_MAX + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_last,
    input  logic [NUM_REQ*DATA_W-1:0]        req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             bus_tx_valid,
    output logic [DATA_W-1:0]                bus_tx_data,
    output logic                             bus_tx_last,
    output logic [$clog2(NUM_REQ)-1:0]       bus_tx_src,
    input  logic                             credit_in,
    output logic [CNT_W-1:0]                 credits,
    output logic                             credit_err
);

    localparam int SRC_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] owner;
    logic [SRC_W-1:0] gnt_idx;
    logic [SRC_W-1:0] rr_next;
    logic             gnt_vld;
    logic             gnt_last;
    logic             xfer;
    int               rr_idx;

    // Next credit count: a beat consumes one, a returned credit adds one,
    // and the count never rises above the receiver buffer depth.
    function automatic logic [CNT_W-1:0] credit_next(
        input logic [CNT_W-1:0] cur,
        input logic             take,
        input logic             give
    );
        if (take && !give)
            return cur - CNT_W'(1);
        if (give && !take)
            return (cur == CNT_W'(CREDIT_MAX)) ? cur : cur + CNT_W'(1);
        return cur;
    endfunction

    // A credit arriving with the counter already full means the receiver
    // returned more than it was ever given.
    function automatic logic credit_ovf(
        input logic [CNT_W-1:0] cur,
        input logic             take,
        input logic             give
    );
        return give && !take && (cur == CNT_W'(CREDIT_MAX));
    endfunction

    // Grant selection: packet owner while bursting, otherwise the first valid
    // requester at or above rr_ptr with wrap. The downward loop lets the
    // closest candidate to rr_ptr win. Nothing is granted without credit.
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        rr_idx    = 0;
        req_ready = '0;
        if (!rst && credits != '0) begin
            if (state == BURST) begin
                if (req_valid[owner]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = owner;
                end
            end else begin
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    rr_idx = int'(rr_ptr) + k;
                    if (rr_idx >= NUM_REQ)
                        rr_idx = rr_idx - NUM_REQ;
                    if (req_valid[rr_idx]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = SRC_W'(rr_idx);
                    end
                end
            end
        end
        if (gnt_vld)
            req_ready[gnt_idx] = 1'b1;
    end

    assign xfer     = gnt_vld;
    assign gnt_last = req_last[gnt_idx];
    assign rr_next  = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);

    // Packet FSM: a non-last beat locks the grant, the last beat releases it
    // and moves the round-robin pointer past the finished requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else if (xfer) begin
            if (gnt_last) begin
                state  <= IDLE;
                rr_ptr <= rr_next;
            end else begin
                state  <= BURST;
                owner  <= gnt_idx;
            end
        end
    end

    // Credit counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits    <= CNT_W'(CREDIT_MAX);
            credit_err <= 1'b0;
        end else begin
            credits <= credit_next(credits, xfer, credit_in);
            if (credit_ovf(credits, xfer, credit_in))
                credit_err <= 1'b1;
        end
    end

    // Output register: the accepted beat appears on the bus one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_tx_valid <= 1'b0;
            bus_tx_data  <= '0;
            bus_tx_last  <= 1'b0;
            bus_tx_src   <= '0;
        end else begin
            bus_tx_valid <= xfer;
            if (xfer) begin
                bus_tx_data <= req_data[int'(gnt_idx)*DATA_W +: DATA_W];
                bus_tx_last <= gnt_last;
                bus_tx_src  <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_pkt_tx_arb.sv
// Bench for pkt_tx_arb: directed stimulus pushes hand-computed beats into a
// queue; a monitor pops and compares every beat the bus presents.
module tb_pkt_tx_arb;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int CNT_W   = 4;

    typedef struct {
        logic [1:0]  src;
        logic [63:0] data;
        logic        last;
    } beat_t;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_last = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      bus_tx_valid;
    logic [DATA_W-1:0]         bus_tx_data;
    logic                      bus_tx_last;
    logic [1:0]                bus_tx_src;
    logic                      credit_in = 1'b0;
    logic [CNT_W-1:0]          credits;
    logic                      credit_err;

    beat_t exp_q[$];
    int    tests  = 0;
    int    failed = 0;

    int exp_src_rr[5]  = '{0, 1, 2, 3, 0};
    int exp_src_cr[8]  = '{1, 2, 3, 0, 1, 2, 3, 0};

    pkt_tx_arb #(.NUM_REQ(4), .DATA_W(64), .CREDIT_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .bus_tx_valid(bus_tx_valid), .bus_tx_data(bus_tx_data),
        .bus_tx_last(bus_tx_last), .bus_tx_src(bus_tx_src),
        .credit_in(credit_in), .credits(credits), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] v, input logic [3:0] l, input logic ci);
        req_valid = v;
        req_last  = l;
        credit_in = ci;
    endtask

    task automatic set_data(input int i, input logic [63:0] d);
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic expect_beat(input int src, input logic [63:0] d, input logic last);
        beat_t b;
        b.src  = 2'(src);
        b.data = d;
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every presented beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (bus_tx_valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL beat_unexpected: got src=%0d data=%0h last=%0b, required none",
                         bus_tx_src, bus_tx_data, bus_tx_last);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                if (bus_tx_src !== e.src || bus_tx_data !== e.data || bus_tx_last !== e.last) begin
                    failed++;
                    $display("FAIL beat: got src=%0d data=%0h last=%0b, required src=%0d data=%0h last=%0b",
                             bus_tx_src, bus_tx_data, bus_tx_last, e.src, e.data, e.last);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) set_data(i, 64'hD0 + 64'(i));

        // Reset, with requesters already asking: nothing may be accepted.
        rst = 1'b1;
        set_in(4'b1111, 4'b1111, 1'b0);
        #1;
        chk("ready_in_rst", 64'(req_ready), 64'h0);
        step();
        step();
        chk("rst_credits", 64'(credits), 64'd8);
        chk("rst_err", 64'(credit_err), 64'd0);
        chk("rst_valid", 64'(bus_tx_valid), 64'd0);
        chk("rst_src", 64'(bus_tx_src), 64'd0);
        chk("rst_last", 64'(bus_tx_last), 64'd0);
        chk("rst_data", bus_tx_data, 64'h0);

        // Round robin over single-beat packets, credits topped up each cycle.
        rst = 1'b0;
        set_in(4'b1111, 4'b1111, 1'b1);
        #1;
        chk("rr_first_ready", 64'(req_ready), 64'h1);
        for (int k = 0; k < 5; k++) begin
            expect_beat(exp_src_rr[k], 64'hD0 + 64'(exp_src_rr[k]), 1'b1);
            step();
        end
        chk("rr_credits", 64'(credits), 64'd8);

        // Move rr_ptr to 2 with a single beat from requester 1.
        set_in(4'b0010, 4'b1111, 1'b1);
        expect_beat(1, 64'hD1, 1'b1);
        step();

        // Three-beat packet from requester 2 while 0 and 1 also wait.
        set_data(2, 64'hE0);
        set_in(4'b0111, 4'b0011, 1'b1);
        expect_beat(2, 64'hE0, 1'b0);
        step();
        set_data(2, 64'hE1);
        #1;
        chk("burst_ready_owner", 64'(req_ready), 64'h4);
        expect_beat(2, 64'hE1, 1'b0);
        step();
        set_in(4'b0011, 4'b0011, 1'b0);
        #1;
        chk("burst_hold_ready", 64'(req_ready), 64'h0);
        step();
        set_data(2, 64'hE2);
        set_in(4'b0111, 4'b0111, 1'b1);
        expect_beat(2, 64'hE2, 1'b1);
        step();
        set_in(4'b0011, 4'b0011, 1'b1);
        #1;
        chk("after_burst_wrap_ready", 64'(req_ready), 64'h1);
        expect_beat(0, 64'hD0, 1'b1);
        step();
        set_in(4'b0000, 4'b0000, 1'b0);
        step();
        chk("burst_credits", 64'(credits), 64'd8);
        chk("burst_err", 64'(credit_err), 64'd0);

        // Drain all credits: exactly eight beats, then nothing.
        set_data(2, 64'hD2);
        set_in(4'b1111, 4'b1111, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (k < 8) expect_beat(exp_src_cr[k], 64'hD0 + 64'(exp_src_cr[k]), 1'b1);
            step();
        end
        chk("drain_credits", 64'(credits), 64'd0);
        chk("drain_ready", 64'(req_ready), 64'h0);
        set_in(4'b1111, 4'b1111, 1'b1);
        #1;
        chk("credit_same_cycle_ready", 64'(req_ready), 64'h0);
        step();
        chk("one_credit", 64'(credits), 64'd1);
        set_in(4'b1111, 4'b1111, 1'b0);
        #1;
        chk("one_credit_ready", 64'(req_ready), 64'h2);
        expect_beat(1, 64'hD1, 1'b1);
        step();
        step();
        chk("one_credit_used", 64'(credits), 64'd0);

        // Return five credits, then transfer and return in the same cycle.
        set_in(4'b0000, 4'b0000, 1'b1);
        repeat (5) step();
        chk("credits_five", 64'(credits), 64'd5);
        set_in(4'b0001, 4'b0001, 1'b1);
        expect_beat(0, 64'hD0, 1'b1);
        step();
        chk("xfer_and_credit", 64'(credits), 64'd5);

        // Overflow: credit while full sets a sticky error.
        set_in(4'b0000, 4'b0000, 1'b1);
        repeat (3) step();
        chk("credits_full", 64'(credits), 64'd8);
        chk("err_before_ovf", 64'(credit_err), 64'd0);
        step();
        chk("credits_saturate", 64'(credits), 64'd8);
        chk("err_set", 64'(credit_err), 64'd1);
        set_in(4'b0000, 4'b0000, 1'b0);
        repeat (3) step();
        chk("err_sticky", 64'(credit_err), 64'd1);

        // Reset in the middle of a packet from requester 1.
        set_in(4'b0010, 4'b0000, 1'b0);
        expect_beat(1, 64'hD1, 1'b0);
        step();
        chk("mid_burst_credits", 64'(credits), 64'd7);
        rst = 1'b1;
        #1;
        chk("burst_rst_ready", 64'(req_ready), 64'h0);
        step();
        rst = 1'b0;
        set_in(4'b0000, 4'b0000, 1'b0);
        chk("burst_rst_credits", 64'(credits), 64'd8);
        chk("burst_rst_valid", 64'(bus_tx_valid), 64'd0);
        chk("burst_rst_src", 64'(bus_tx_src), 64'd0);
        chk("burst_rst_err", 64'(credit_err), 64'd0);
        set_in(4'b1001, 4'b1001, 1'b0);
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'h1);
        expect_beat(0, 64'hD0, 1'b1);
        step();
        set_in(4'b0000, 4'b0000, 1'b0);
        step();
        step();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
